// File: rtl/vector_list_sequencer_if.sv
// Beam-side and list-RAM-side signals of the vector list sequencer.
// The master is the sequencer; the slave is the RAM / beam controller side.
interface vector_list_sequencer_if #(
    parameter int ADDR_W  = 8,
    parameter int COORD_W = 12
);
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_rd;
    logic [2*COORD_W+1:0] mem_data;
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
    logic                 jump;
    logic                 draw;
    logic                 ready;

    modport master (
        output mem_addr, mem_rd, x, y, jump, draw,
        input  mem_data, ready
    );

    modport slave (
        input  mem_addr, mem_rd, x, y, jump, draw,
        output mem_data, ready
    );
endinterface

// File: rtl/vector_list_sequencer.sv
// Walks a display list once per frame and issues jump/draw pulses to the beam controller.
// List word: {op[1:0], y, x}; op 00=JUMP, 01=DRAW, 10=END, 11=NOP.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for frame_tick with enable set
// S_FETCH    | mem_rd strobe for the word at mem_addr
// S_WAIT_RD  | RAM read latency; word registered (x/y captured for JUMP/DRAW)
// S_DECODE   | act on op: finish frame, skip NOP, or prepare a command
// S_ISSUE    | one-cycle jump/draw pulse while ready=1
// S_SETTLE   | dead cycle that lets the controller drop ready
// S_WAIT_RDY | hold until ready; then issue pending command or advance
module vector_list_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int COORD_W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     frame_tick,
    vector_list_sequencer_if.master  vl,
    output logic                     busy,
    output logic                     overrun,
    output logic [ADDR_W:0]          cmd_count
);

    localparam int WORD_W = 2*COORD_W + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W:0]   CNT_MAX   = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_DECODE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT_RDY
    } state_t;

    typedef enum logic [1:0] {
        OP_JUMP = 2'b00,
        OP_DRAW = 2'b01,
        OP_END  = 2'b10,
        OP_NOP  = 2'b11
    } op_t;

    state_t          state, state_n;
    op_t             word_op;
    logic            pending;
    logic [ADDR_W:0] counter;

    logic start, finish, advance, latch_word, set_pend, issued;

    assign busy = (state != S_IDLE);

    // State register; a synchronous reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state decode and the combinational command/strobe outputs.
    always_comb begin
        state_n    = state;
        vl.mem_rd  = 1'b0;
        vl.jump    = 1'b0;
        vl.draw    = 1'b0;
        start      = 1'b0;
        finish     = 1'b0;
        advance    = 1'b0;
        latch_word = 1'b0;
        set_pend   = 1'b0;
        issued     = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_tick && enable) begin
                    start   = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                vl.mem_rd = 1'b1;
                state_n   = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                latch_word = 1'b1;
                state_n    = S_DECODE;
            end
            S_DECODE: begin
                case (word_op)
                    OP_END: begin
                        finish  = 1'b1;
                        state_n = S_IDLE;
                    end
                    OP_NOP: begin
                        // The last list slot ends the frame instead of wrapping to 0.
                        if (vl.mem_addr == LAST_ADDR) begin
                            finish  = 1'b1;
                            state_n = S_IDLE;
                        end else begin
                            advance = 1'b1;
                            state_n = S_FETCH;
                        end
                    end
                    default: begin
                        set_pend = 1'b1;
                        state_n  = vl.ready ? S_ISSUE : S_WAIT_RDY;
                    end
                endcase
            end
            S_ISSUE: begin
                // If ready fell after decode the command stays pending.
                if (vl.ready) begin
                    vl.jump = (word_op == OP_JUMP);
                    vl.draw = (word_op == OP_DRAW);
                    issued  = 1'b1;
                    state_n = S_SETTLE;
                end else begin
                    state_n = S_WAIT_RDY;
                end
            end
            S_SETTLE: begin
                state_n = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (vl.ready) begin
                    if (pending) begin
                        state_n = S_ISSUE;
                    end else if (vl.mem_addr == LAST_ADDR) begin
                        finish  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        advance = 1'b1;
                        state_n = S_FETCH;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath: list address, coordinate latches, command counter and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            vl.mem_addr <= '0;
            vl.x        <= '0;
            vl.y        <= '0;
            word_op     <= OP_NOP;
            pending     <= 1'b0;
            counter     <= '0;
            cmd_count   <= '0;
            overrun     <= 1'b0;
        end else begin
            if (frame_tick && busy)
                overrun <= 1'b1;
            if (start) begin
                vl.mem_addr <= '0;
                counter     <= '0;
            end
            if (advance)
                vl.mem_addr <= vl.mem_addr + 1'b1;
            if (latch_word) begin
                word_op <= op_t'(vl.mem_data[WORD_W-1 -: 2]);
                // Capturing x/y straight off the RAM puts them on the bus a full
                // cycle before the pulse; NOP/END words leave them untouched.
                if (!vl.mem_data[WORD_W-1]) begin
                    vl.y <= vl.mem_data[2*COORD_W-1 -: COORD_W];
                    vl.x <= vl.mem_data[COORD_W-1:0];
                end
            end
            if (set_pend)
                pending <= 1'b1;
            if (issued) begin
                pending <= 1'b0;
                if (counter != CNT_MAX)
                    counter <= counter + 1'b1;
            end
            if (finish)
                cmd_count <= counter;
        end
    end

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Directed bench for vector_list_sequencer: list RAM model, pulse monitor, hand-computed checks.
module tb_vector_list_sequencer;

    localparam int AW = 8;
    localparam int CW = 12;
    localparam int WW = 2*CW + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, enable, frame_tick, frame_tick2, ready;
    logic          busy, overrun, busy2, overrun2;
    logic [AW:0]   cmd_count;
    logic [2:0]    cmd_count2;

    vector_list_sequencer_if #(.ADDR_W(AW), .COORD_W(CW)) vl();
    vector_list_sequencer_if #(.ADDR_W(2),  .COORD_W(CW)) vl2();

    vector_list_sequencer #(.ADDR_W(AW), .COORD_W(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
        .vl(vl.master), .busy(busy), .overrun(overrun), .cmd_count(cmd_count)
    );

    vector_list_sequencer #(.ADDR_W(2), .COORD_W(CW)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick2),
        .vl(vl2.master), .busy(busy2), .overrun(overrun2), .cmd_count(cmd_count2)
    );

    // synchronous-read list RAMs
    logic [WW-1:0] mem  [0:255];
    logic [WW-1:0] mem2 [0:3];
    logic [WW-1:0] rd_q  = '0;
    logic [WW-1:0] rd_q2 = '0;
    always @(posedge clk) if (vl.mem_rd)  rd_q  <= mem[vl.mem_addr];
    always @(posedge clk) if (vl2.mem_rd) rd_q2 <= mem2[vl2.mem_addr];
    assign vl.mem_data  = rd_q;
    assign vl.ready     = ready;
    assign vl2.mem_data = rd_q2;
    assign vl2.ready    = ready;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitor, sampled on the falling edge
    int   np = 0, both_cnt = 0, np2 = 0, jmp2 = 0, lastx2 = 0;
    logic pk  [0:15];
    int   pxs [0:15];
    int   pys [0:15];
    int   pcs [0:15];
    always @(negedge clk) begin
        if (vl.jump && vl.draw) both_cnt++;
        if ((vl.jump || vl.draw) && np < 16) begin
            pk[np]  = vl.draw;
            pxs[np] = int'(vl.x);
            pys[np] = int'(vl.y);
            pcs[np] = cyc;
            np++;
        end
        if (vl2.draw) begin
            np2++;
            lastx2 = int'(vl2.x);
        end
        if (vl2.jump) jmp2++;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] mkw(input logic [1:0] op, input int x, input int y);
        logic [CW-1:0] xs, ys;
        xs = CW'(x);
        ys = CW'(y);
        return {op, ys, xs};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 1000) begin
            step(1);
            k++;
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_np(input int n, input string tag);
        int k = 0;
        while (np < n && k < 1000) begin
            step(1);
            k++;
        end
        chk({tag, "_pulse_seen"}, (np >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic load_basic();
        for (int i = 0; i < 256; i++) mem[i] = mkw(2'b10, 0, 0);
        mem[0] = mkw(2'b00, 100, 200);
        mem[1] = mkw(2'b01, 300, 400);
        mem[2] = mkw(2'b10, 0, 0);
    endtask

    int bad_hold;
    int ready_cyc;

    initial begin
        reset = 1'b1; enable = 1'b0; frame_tick = 1'b0; frame_tick2 = 1'b0; ready = 1'b1;
        for (int i = 0; i < 4; i++) mem2[i] = mkw(2'b01, i + 1, 10*i);
        load_basic();
        step(3);
        reset = 1'b0;
        step(1);

        // reset state
        chk("rst_addr",   32'(vl.mem_addr), 0);
        chk("rst_rd",     32'(vl.mem_rd), 0);
        chk("rst_x",      32'(vl.x), 0);
        chk("rst_y",      32'(vl.y), 0);
        chk("rst_pulses", 32'(vl.jump | vl.draw), 0);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_ovr",    32'(overrun), 0);
        chk("rst_cnt",    32'(cmd_count), 0);

        // tick with enable low is ignored
        pulse_tick();
        step(10);
        chk("dis_busy", 32'(busy), 0);
        chk("dis_np",   32'(np), 0);

        // JUMP, DRAW, END with ready held high
        enable = 1'b1;
        np = 0;
        pulse_tick();
        wait_idle("t1");
        chk("t1_np",      32'(np), 2);
        chk("t1_k0",      32'(pk[0]), 0);
        chk("t1_x0",      32'(pxs[0]), 100);
        chk("t1_y0",      32'(pys[0]), 200);
        chk("t1_k1",      32'(pk[1]), 1);
        chk("t1_x1",      32'(pxs[1]), 300);
        chk("t1_y1",      32'(pys[1]), 400);
        chk("t1_gap_ge5", (pcs[1] - pcs[0] >= 5) ? 32'd1 : 32'd0, 1);
        chk("t1_cnt",     32'(cmd_count), 2);
        step(20);
        chk("t1_no_more", 32'(np), 2);

        // ready dropped for 20 cycles after the jump
        np = 0;
        pulse_tick();
        wait_np(1, "t2");
        step(1);
        ready = 1'b0;
        bad_hold = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (vl.x != 12'd100 || vl.y != 12'd200 || np != 1) bad_hold++;
        end
        chk("t2_hold", 32'(bad_hold), 0);
        ready_cyc = cyc;
        ready = 1'b1;
        wait_idle("t2");
        chk("t2_np",    32'(np), 2);
        chk("t2_k1",    32'(pk[1]), 1);
        chk("t2_x1",    32'(pxs[1]), 300);
        chk("t2_y1",    32'(pys[1]), 400);
        chk("t2_after", (pcs[1] > ready_cyc) ? 32'd1 : 32'd0, 1);
        chk("t2_cnt",   32'(cmd_count), 2);

        // NOP, NOP, DRAW(4095,0), END
        mem[0] = mkw(2'b11, 0, 0);
        mem[1] = mkw(2'b11, 0, 0);
        mem[2] = mkw(2'b01, 4095, 0);
        mem[3] = mkw(2'b10, 0, 0);
        np = 0;
        pulse_tick();
        wait_idle("t3");
        chk("t3_np",  32'(np), 1);
        chk("t3_k0",  32'(pk[0]), 1);
        chk("t3_x0",  32'(pxs[0]), 4095);
        chk("t3_y0",  32'(pys[0]), 0);
        chk("t3_cnt", 32'(cmd_count), 1);

        // second tick mid-frame: overrun, no restart
        load_basic();
        np = 0;
        pulse_tick();
        step(3);
        pulse_tick();
        wait_idle("t4");
        chk("t4_ovr", 32'(overrun), 1);
        chk("t4_np",  32'(np), 2);
        chk("t4_cnt", 32'(cmd_count), 2);
        step(30);
        chk("t4_no_restart", 32'(np), 2);
        pulse_tick();
        wait_idle("t4b");
        chk("t4_np2",  32'(np), 4);
        chk("t4_ovr2", 32'(overrun), 1);

        // enable dropped mid-frame: frame completes, no new frame
        np = 0;
        pulse_tick();
        step(2);
        enable = 1'b0;
        wait_idle("t5");
        chk("t5_np", 32'(np), 2);
        pulse_tick();
        step(20);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_np2",  32'(np), 2);
        enable = 1'b1;

        // reset one cycle after a jump pulse
        np = 0;
        pulse_tick();
        wait_np(1, "t6");
        step(1);
        reset = 1'b1;
        step(1);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_x",    32'(vl.x), 0);
        chk("t6_y",    32'(vl.y), 0);
        chk("t6_addr", 32'(vl.mem_addr), 0);
        chk("t6_ovr",  32'(overrun), 0);
        chk("t6_cnt",  32'(cmd_count), 0);
        reset = 1'b0;
        step(30);
        chk("t6_no_draw", 32'(np), 1);

        // 4-word list, no END: stops after the last slot
        frame_tick2 = 1'b1;
        step(1);
        frame_tick2 = 1'b0;
        for (int k = 0; k < 1000 && busy2; k++) step(1);
        chk("t7_idle",  32'(busy2), 0);
        chk("t7_np",    32'(np2), 4);
        chk("t7_jmp",   32'(jmp2), 0);
        chk("t7_lastx", 32'(lastx2), 4);
        chk("t7_cnt",   32'(cmd_count2), 4);
        step(20);
        chk("t7_no_wrap", 32'(np2), 4);

        chk("never_both", 32'(both_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
